cache_core_responder: RTL and testbench
=======================================

// Module: cache_core_responder
// PURPOSE
//  Cache-side responder for the core<->cache request interface: accepts
//  single-cycle rd_en/wr_en pulses with 27-bit byte addresses, serves them
//  from a word-addressed backing store and answers with a one-cycle fin pulse.
//  Models a direct-mapped tag array (13b tag / 10b index / 4b offset) so
//  hit and miss latencies differ. Used as the cache stand-in when
//  bringing up core-side traffic generators and the FPU load/store path.
// PARAMETERS
//  HIT_LAT   2    cycles from accepted request to fin on a tag hit (>=1)
//  MISS_LAT  20   cycles from accepted request to fin on a tag miss (>=HIT_LAT)
//  MEM_AW    12   backing store depth = 2**MEM_AW words, indexed by addr[MEM_AW+1:2]
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous reset, active-high
//  core2cache_rd_en    in   1   read request pulse
//  core2cache_rd_addr  in   27  read byte address {tag13,index10,offset4}
//  core2cache_wr_en    in   1   write request pulse
//  core2cache_wr_addr  in   27  write byte address
//  core2cache_wr_data  in   32  write data
//  cache2core_rd_fin   out  1   one-cycle read completion pulse
//  cache2core_rd_data  out  32  read data, valid with rd_fin, held until next rd_fin
//  cache2core_wr_fin   out  1   one-cycle write completion pulse
//  proto_err           out  1   sticky: request dropped (busy or rd+wr same cycle)
//  hit_cnt             out  32  saturating count of tag hits
//  miss_cnt            out  32  saturating count of tag misses
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, all tag valid bits cleared (flop vector,
//    one cycle). Store contents not reset. Reset mid-op aborts: no fin issued.
//  - FSM IDLE -> WAIT on accepted request; WAIT -> DONE when lat_cnt hits 1;
//    DONE pulses the matching fin for exactly one cycle, -> IDLE.
//  - Acceptance only in IDLE. Lookup in acceptance cycle: hit = valid[index]
//    && tag[index]==addr[26:14]. Hit: lat_cnt<=HIT_LAT-1, hit_cnt++. Miss:
//    lat_cnt<=MISS_LAT-1, miss_cnt++, tag[index]<=addr tag, valid<=1
//    (allocate on read and write). HIT_LAT=1 -> straight to DONE.
//  - Total latency: fin asserted exactly LAT cycles after the rd_en/wr_en edge.
//  - Writes commit to store in acceptance cycle (addr[1:0] ignored, full word).
//    Read data sampled from store in acceptance cycle, registered to rd_data
//    on the DONE cycle; a read following a completed write returns new data.
//  - rd_en && wr_en same cycle in IDLE: write accepted, read dropped, proto_err<=1.
//  - Any request while WAIT/DONE: dropped, proto_err<=1, state unaffected.
//  - Next request may arrive the cycle after fin (IDLE); back-to-back OK.
//  - Counters saturate at 32'hFFFF_FFFF, never wrap.
// STRUCTURE
//  - Shared package: ADDR_W=27, TAG_W=13, IDX_W=10, OFF_W=4 and field-slice
//    macros, shared with the core-side initiator; FSM state encoding local.
//  - One sub-module: cache_tag_dm (tag+valid array, lookup/allocate, clear on rst).
//  - Backing store: inferred single-port RAM, write-first.
// TESTING
//  1 wr 0x0000010 data 0x1234 -> wr_fin at +20 (miss); rd same addr -> rd_fin at
//    +2, rd_data=0x1234; hit_cnt=1 miss_cnt=1.
//  2 rd tag 1 idx 5, then rd tag 2 idx 5, then tag 1 idx 5 -> latencies 20,20,20
//    (conflict eviction); repeat tag 1 -> 2.
//  3 rd_en+wr_en same cycle addr 0x40 data 0xAA -> only wr_fin, proto_err=1;
//    later read 0x40 -> 0xAA.
//  4 second rd_en 3 cycles into a miss -> ignored, single rd_fin, proto_err=1.
//  5 rst asserted mid-miss -> no fin; post-reset read of prior hit addr misses.
//  6 100 writes then 100 reads with stride-increment addresses -> all data match,
//    hit_cnt+miss_cnt=200, every fin exactly one cycle wide.

Source files
------------

// File: rtl/cache_core_responder_pkg.sv
// Shared address-field definitions for the core<->cache request interface,
// used by both the cache-side responder and the core-side initiator.
package cache_core_responder_pkg;

    localparam int ADDR_W = 27;
    localparam int TAG_W  = 13;
    localparam int IDX_W  = 10;
    localparam int OFF_W  = 4;
    localparam int DATA_W = 32;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/cache_tag_dm.sv
// Direct-mapped tag array: combinational lookup, allocate-on-request, and a
// flop-vector of valid bits cleared in a single reset cycle.
module cache_tag_dm
    import cache_core_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [TAG_W-1:0] tag,
    input  logic             alloc,
    output logic             hit
);

    logic [TAG_W-1:0]    tag_mem [2**IDX_W];
    logic [2**IDX_W-1:0] valid;

    assign hit = valid[idx] && (tag_mem[idx] == tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (alloc) begin
            valid[idx] <= 1'b1;
        end
    end

    // Tag storage needs no reset: the valid vector qualifies every entry.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_mem[idx] <= tag;
        end
    end

endmodule

// File: rtl/cache_core_responder.sv
// Cache stand-in answering single-cycle core requests from a word-addressed
// store, with hit/miss latency chosen by a direct-mapped tag model.
module cache_core_responder
    import cache_core_responder_pkg::*;
#(
    parameter int HIT_LAT  = 2,
    parameter int MISS_LAT = 20,
    parameter int MEM_AW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core2cache_rd_en,
    input  logic [ADDR_W-1:0] core2cache_rd_addr,
    input  logic              core2cache_wr_en,
    input  logic [ADDR_W-1:0] core2cache_wr_addr,
    input  logic [DATA_W-1:0] core2cache_wr_data,
    output logic              cache2core_rd_fin,
    output logic [DATA_W-1:0] cache2core_rd_data,
    output logic              cache2core_wr_fin,
    output logic              proto_err,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is a one-cycle rd_en/wr_en pulse, taken only in
    // IDLE; completion is a one-cycle fin pulse, rd_data valid alongside it.
    localparam int LAT_W = $clog2(MISS_LAT) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [LAT_W-1:0]    lat_cnt;
    logic                op_rd, next_rd;
    logic                req_any, accept, drop, lk_hit, fast, enter_done;
    logic [ADDR_W-1:0]   req_addr;
    logic [MEM_AW-1:0]   word_addr;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [DATA_W-1:0]   mem [2**MEM_AW];
    logic [DATA_W-1:0]   mem_q, rd_buf;
    logic                unused_byte_bits;

    assign req_any    = core2cache_rd_en | core2cache_wr_en;
    assign accept     = !rst && (state == IDLE) && req_any;
    assign drop       = req_any && ((state != IDLE) || (core2cache_rd_en && core2cache_wr_en));
    assign req_addr   = core2cache_wr_en ? core2cache_wr_addr : core2cache_rd_addr;
    assign word_addr  = req_addr[MEM_AW+1:2];
    assign req_idx    = addr_idx(req_addr);
    assign req_tag    = addr_tag(req_addr);
    assign fast       = lk_hit ? (HIT_LAT == 1) : (MISS_LAT == 1);
    assign next_rd    = accept ? !core2cache_wr_en : op_rd;
    assign enter_done = (state_nxt == DONE) && (state != DONE);
    assign dbg_state  = state;
    assign unused_byte_bits = ^req_addr[1:0];

    cache_tag_dm u_tag (
        .clk   (clk),
        .rst   (rst),
        .idx   (req_idx),
        .tag   (req_tag),
        .alloc (accept && !lk_hit),
        .hit   (lk_hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? DONE : WAIT;
            WAIT:    if (lat_cnt == LAT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            lat_cnt            <= '0;
            op_rd              <= 1'b0;
            cache2core_rd_fin  <= 1'b0;
            cache2core_wr_fin  <= 1'b0;
            cache2core_rd_data <= '0;
            proto_err          <= 1'b0;
            hit_cnt            <= '0;
            miss_cnt           <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_rd   <= !core2cache_wr_en;
                lat_cnt <= lk_hit ? LAT_W'(HIT_LAT - 1) : LAT_W'(MISS_LAT - 1);
                if (lk_hit && (hit_cnt != '1))
                    hit_cnt <= hit_cnt + 32'd1;
                if (!lk_hit && (miss_cnt != '1))
                    miss_cnt <= miss_cnt + 32'd1;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (drop)
                proto_err <= 1'b1;
            cache2core_rd_fin <= enter_done && next_rd;
            cache2core_wr_fin <= enter_done && !next_rd;
            // Single-cycle hits skip WAIT, so take the store output directly.
            if (enter_done && next_rd)
                cache2core_rd_data <= accept ? mem_q : rd_buf;
        end
    end

    assign mem_q = mem[word_addr];

    always_ff @(posedge clk) begin
        if (accept && core2cache_wr_en)
            mem[word_addr] <= core2cache_wr_data;
        if (accept)
            rd_buf <= core2cache_wr_en ? core2cache_wr_data : mem_q;
    end

endmodule

// File: tb/tb_cache_core_responder.sv
// Directed bench for cache_core_responder: drivers push expected completions
// (kind, data, due cycle) into a queue that a negedge monitor pops and checks.
module tb_cache_core_responder;

    localparam int HIT_LAT  = 2;
    localparam int MISS_LAT = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [26:0] rd_addr = '0, wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_fin, wr_fin, proto_err;
    logic [31:0] rd_data, hit_cnt, miss_cnt;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    // {is_wr, data, due_cycle}
    logic [64:0] exp_q[$];

    cache_core_responder #(.HIT_LAT(HIT_LAT), .MISS_LAT(MISS_LAT), .MEM_AW(12)) dut (
        .clk                (clk),
        .rst                (rst),
        .core2cache_rd_en   (rd_en),
        .core2cache_rd_addr (rd_addr),
        .core2cache_wr_en   (wr_en),
        .core2cache_wr_addr (wr_addr),
        .core2cache_wr_data (wr_data),
        .cache2core_rd_fin  (rd_fin),
        .cache2core_rd_data (rd_data),
        .cache2core_wr_fin  (wr_fin),
        .proto_err          (proto_err),
        .hit_cnt            (hit_cnt),
        .miss_cnt           (miss_cnt),
        .dbg_state          (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst && (rd_fin || wr_fin)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_fin: got rd_fin=%0b wr_fin=%0b expected none (cycle %0d)",
                         rd_fin, wr_fin, cyc);
            end else begin
                e = exp_q.pop_front();
                check("single_fin", {31'b0, rd_fin & wr_fin}, 32'd0);
                check("fin_kind_wr", {31'b0, wr_fin}, {31'b0, e[64]});
                check("fin_cycle", cyc, e[31:0]);
                if (!e[64])
                    check("rd_data", rd_data, e[63:32]);
            end
        end
    end

    // driver: kind 0 = read, 1 = write, 2 = read+write in the same cycle
    task automatic issue(input int kind, input logic [26:0] a, input logic [31:0] d, input int lat);
        exp_q.push_back({(kind != 0), d, 32'(cyc + lat)});
        if (lat == HIT_LAT) exp_hit++;
        else exp_miss++;
        rd_en   = (kind != 1);
        wr_en   = (kind != 0);
        rd_addr = a;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL fin_timeout: got %0d pending expected 0 (cycle %0d)", exp_q.size(), cyc);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hit));
        check({tag, "_miss_cnt"}, miss_cnt, 32'(exp_miss));
    endtask

    task automatic do_op(input int kind, input logic [26:0] a, input logic [31:0] d, input int lat);
        issue(kind, a, d, lat);
        wait_done();
    endtask

    initial begin
        // reset block
        repeat (3) @(negedge clk);
        check("rst_rd_fin", {31'b0, rd_fin}, 32'd0);
        check("rst_wr_fin", {31'b0, wr_fin}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_proto_err", {31'b0, proto_err}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        check_cnts("rst");
        rst = 1'b0;
        @(negedge clk);

        // 1: write miss, read hit
        do_op(1, 27'h0000010, 32'h0000_1234, MISS_LAT);
        do_op(0, 27'h0000010, 32'h0000_1234, HIT_LAT);
        check("t1_hit_cnt", hit_cnt, 32'd1);
        check("t1_miss_cnt", miss_cnt, 32'd1);

        // 2: conflict eviction on index 5 (tags 1 and 2 alias the same store word)
        do_op(1, 27'h0004050, 32'hAAAA_0001, MISS_LAT);
        do_op(1, 27'h0008050, 32'hBBBB_0002, MISS_LAT);
        do_op(0, 27'h0004050, 32'hBBBB_0002, MISS_LAT);
        do_op(0, 27'h0008050, 32'hBBBB_0002, MISS_LAT);
        do_op(0, 27'h0004050, 32'hBBBB_0002, MISS_LAT);
        do_op(0, 27'h0004050, 32'hBBBB_0002, HIT_LAT);
        check_cnts("t2");
        check("t2_proto_err", {31'b0, proto_err}, 32'd0);

        // 3: read and write together: write wins, error flagged
        do_op(2, 27'h0000040, 32'h0000_00AA, MISS_LAT);
        check("t3_proto_err", {31'b0, proto_err}, 32'd1);
        do_op(0, 27'h0000040, 32'h0000_00AA, HIT_LAT);
        check_cnts("t3");

        // clear the sticky error and tags
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        @(negedge clk);
        check("t4_pre_proto_err", {31'b0, proto_err}, 32'd0);
        check_cnts("t4_pre");

        // 4: second request 3 cycles into a miss is dropped
        issue(0, 27'h0000010, 32'h0000_1234, MISS_LAT);
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        rd_addr = 27'h0004050;
        @(negedge clk);
        rd_en = 1'b0;
        check("t4_proto_err", {31'b0, proto_err}, 32'd1);
        wait_done();
        check_cnts("t4");

        // 5: reset in the middle of a miss aborts it
        do_op(0, 27'h0000010, 32'h0000_1234, HIT_LAT);
        issue(0, 27'h0004050, 32'hBBBB_0002, MISS_LAT);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        repeat (30) @(negedge clk);
        check("t5_state", {30'b0, dbg_state}, 32'd0);
        check_cnts("t5_post_rst");
        do_op(0, 27'h0000010, 32'h0000_1234, MISS_LAT);
        check_cnts("t5");

        // 6: 100 strided writes (all miss) then 100 reads (all hit)
        for (int i = 0; i < 100; i++)
            do_op(1, 27'(32'h1000 + 32'(i) * 32'h10), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101), MISS_LAT);
        for (int i = 0; i < 100; i++)
            do_op(0, 27'(32'h1000 + 32'(i) * 32'h10), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101), HIT_LAT);
        check_cnts("t6");
        check("t6_total", hit_cnt + miss_cnt, 32'd201);
        check("t6_proto_err", {31'b0, proto_err}, 32'd0);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
